pipe_skid_reg: RTL and testbench

// - Parametrised pipeline-stage register; the edge-triggered successor of the per-bit 32-bit latch array.
// - Carries one WIDTH-bit payload per cycle between pipeline stages using a valid/ready handshake.
// - A one-entry skid buffer keeps full throughput when the downstream stalls, and ready_o is driven from a flop.
// - Synchronous flush_i squashes in-flight data; it is used on branch/jump redirect in the core pipeline.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_data_reg.sv | 26 ++
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 tb/tb_pipe_skid_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid-register stage.
// Holds the stage state encoding and the core's NOP encoding used as the flush value.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [1:0] state_count(input pipe_state_e s);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (s)
      PS_ONE:  cnt = 2'd1;
      PS_TWO:  cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Loadable WIDTH-bit register with asynchronous active-low reset.
// Used for both the main output register and the skid register.
module pipe_data_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= RST_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a one-entry skid buffer and synchronous flush.
// ready_o, valid_o and count_o come straight from flops, so neither handshake input reaches them.
//
// state    | meaning
// ---------+---------------------------------------------------
// PS_EMPTY | nothing held; data_o stale
// PS_ONE   | data_o holds the head payload, skid free
// PS_TWO   | data_o holds the head, skid holds the next payload
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  pipe_state_e      state_q, state_d;
  logic             valid_q, ready_q;
  logic [1:0]       count_q;
  logic             acc, out;
  logic             main_load, skid_load, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_d, skid_q;

  assign acc = valid_i & ready_q;
  assign out = valid_q & ready_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d   = PS_EMPTY;
      main_load = 1'b1;
      skid_load = 1'b1;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (acc) begin
            state_d   = PS_ONE;
            main_load = 1'b1;
          end
        end
        PS_ONE: begin
          if (acc && out) begin
            main_load = 1'b1;
          end else if (acc) begin
            state_d   = PS_TWO;
            skid_load = 1'b1;
          end else if (out) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (out) begin
            state_d        = PS_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  assign main_d = flush_i ? FLUSH_VAL : (main_from_skid ? skid_q : data_i);
  assign skid_d = flush_i ? FLUSH_VAL : data_i;

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PS_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != PS_EMPTY);
      ready_q <= (state_d != PS_TWO);
      count_q <= state_count(state_d);
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_VAL)) u_main_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (data_o)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_VAL)) u_skid_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (skid_load),
    .d_i    (skid_d),
    .q_o    (skid_q)
  );

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a random run,
// all checked against a FIFO scoreboard of accepted payloads.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int unsigned W  = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;
  localparam logic [W-1:0] FV = NOP_INSTR;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i, valid_i, ready_i;
  logic [W-1:0] data_i;
  logic         ready_o, valid_o;
  logic [W-1:0] data_o;
  logic [1:0]   count_o;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_data = '0;

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .FLUSH_VAL(FV)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  // One clock: compare outputs with the scoreboard, then advance it.
  task automatic step();
    logic acc, out;
    int   sz;
    @(negedge clk);
    sz = exp_q.size();
    n_checks++;
    if (valid_o !== (sz > 0)) begin
      n_errors++; $display("FAIL valid_o got %0b want %0b", valid_o, (sz > 0));
    end
    n_checks++;
    if (ready_o !== (sz < 2)) begin
      n_errors++; $display("FAIL ready_o got %0b want %0b", ready_o, (sz < 2));
    end
    n_checks++;
    if (count_o !== 2'(sz)) begin
      n_errors++; $display("FAIL count_o got %0d want %0d", count_o, sz);
    end
    if (sz > 0) begin
      n_checks++;
      if (data_o !== exp_q[0]) begin
        n_errors++; $display("FAIL data_order got %h want %h", data_o, exp_q[0]);
      end
    end
    if (stall_q) begin
      n_checks++;
      if (data_o !== stall_data) begin
        n_errors++; $display("FAIL stall_stable got %h want %h", data_o, stall_data);
      end
    end
    acc        = valid_i && (sz < 2);
    out        = (sz > 0) && ready_i;
    stall_q    = (sz > 0) && !ready_i && !flush_i;
    stall_data = data_o;
    if (flush_i) begin
      exp_q.delete();
    end else begin
      if (out) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(data_i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) step();
  endtask

  task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
    ready_i = 1'b0; valid_i = 1'b1; flush_i = 1'b0;
    data_i = a; step();
    data_i = b; step();
    valid_i = 1'b0; data_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (data_o !== RV || valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 2'd0) begin
      n_errors++; $display("FAIL reset_init got v%0b r%0b c%0d d%h want v0 r1 c0 d%h",
                           valid_o, ready_o, count_o, data_o, RV);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fill_two(32'h1111_0001, 32'h2222_0002);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (data_o !== RV || valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 2'd0) begin
      n_errors++; $display("FAIL reset_midstream got v%0b r%0b c%0d d%h want v0 r1 c0 d%h",
                           valid_o, ready_o, count_o, data_o, RV);
    end
    exp_q.delete();
    stall_q = 1'b0;
    rst_n   = 1'b1;
    valid_i = 1'b1; ready_i = 1'b0; data_i = 32'h5555_0055;
    step();
    valid_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h5555_0055) begin
      n_errors++; $display("FAIL reset_first_acc got v%0b d%h want v1 d55550055", valid_o, data_o);
    end
    drain();
  endtask

  task automatic test_stream();
    ready_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      data_i = W'(k);
      step();
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== W'(k)) begin
        n_errors++; $display("FAIL stream_%0d got v%0b d%h want v1 d%h", k, valid_o, data_o, W'(k));
      end
    end
    drain();
  endtask

  task automatic test_skid();
    fill_two(32'hAAAA_0001, 32'hBBBB_0002);
    step();
    n_checks++;
    if (count_o !== 2'd2 || ready_o !== 1'b0 || data_o !== 32'hAAAA_0001) begin
      n_errors++; $display("FAIL skid_full got c%0d r%0b d%h want c2 r0 dAAAA0001", count_o, ready_o, data_o);
    end
    ready_i = 1'b1;
    step();
    n_checks++;
    if (ready_o !== 1'b1 || data_o !== 32'hBBBB_0002 || count_o !== 2'd1) begin
      n_errors++; $display("FAIL skid_release got r%0b c%0d d%h want r1 c1 dBBBB0002", ready_o, count_o, data_o);
    end
    step();
    n_checks++;
    if (valid_o !== 1'b0 || count_o !== 2'd0) begin
      n_errors++; $display("FAIL skid_drained got v%0b c%0d want v0 c0", valid_o, count_o);
    end
    drain();
  endtask

  task automatic test_flush();
    fill_two(32'hC0C0_0003, 32'hD0D0_0004);
    flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'hE0E0_0005;
    step();
    idle_inputs();
    n_checks++;
    if (valid_o !== 1'b0 || count_o !== 2'd0 || data_o !== FV) begin
      n_errors++; $display("FAIL flush got v%0b c%0d d%h want v0 c0 d%h", valid_o, count_o, data_o, FV);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_errors++; $display("FAIL flush_leak got v%0b d%h want v0", valid_o, data_o);
      end
    end
  endtask

  task automatic test_simul();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h0000_00A5;
    step();
    ready_i = 1'b1; data_i = 32'h0000_005A;
    step();
    valid_i = 1'b0;
    n_checks++;
    if (data_o !== 32'h0000_005A || count_o !== 2'd1) begin
      n_errors++; $display("FAIL simul got c%0d d%h want c1 d0000005a", count_o, data_o);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 10000; k++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 49) == 0);
      data_i  = W'($urandom);
      step();
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0 || valid_o !== 1'b0) begin
      n_errors++; $display("FAIL random_drain got q%0d v%0b want q0 v0", exp_q.size(), valid_o);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_simul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
